// File: rtl/spi_frame_pkg.sv
// Shared types for the SPI game-frame receiver: FSM states, status byte layout, default header.
package spi_frame_pkg;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECK,
    DONE,
    DRAIN
  } rx_state_t;

  typedef struct packed {
    logic       overrun;
    logic       len_err;
    logic       cks_err;
    logic       hdr_err;
    logic [3:0] accepted;
  } status_byte_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer followed by a registered edge detector; level/rise/fall are aligned.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], din};
      level <= sync[SYNC_STAGES-1];
      rise  <= sync[SYNC_STAGES-1] & ~level;
      fall  <= ~sync[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_frame_receiver.sv
// Oversampled SPI packet receiver: header/payload/checksum framing, error-checked commit,
// valid/ready payload delivery and a read-to-clear status byte shifted out on sdo.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  HEADER_BYTE   = HEADER_BYTE_DEFAULT,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                       HSOSC_clk,
  input  logic                       reset_n,
  input  logic                       sck,
  input  logic                       sdi,
  input  logic                       ce,
  output logic                       sdo,
  output logic [PAYLOAD_BYTES*8-1:0] frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       busy,
  output logic [7:0]                 err_count
);

  localparam int unsigned FRAME_W = PAYLOAD_BYTES * 8;
  localparam int unsigned CNT_W   = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic ce_lvl, ce_rise, ce_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(HSOSC_clk), .rst_n(reset_n), .din(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(HSOSC_clk), .rst_n(reset_n), .din(sdi), .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
    .clk(HSOSC_clk), .rst_n(reset_n), .din(ce), .level(ce_lvl), .rise(ce_rise), .fall(ce_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_lvl, sdi_rise, sdi_fall, ce_lvl};

  rx_state_t          state, next_state;
  logic [7:0]         shreg;
  logic [2:0]         bit_cnt;
  logic [CNT_W-1:0]   byte_cnt;
  logic [7:0]         cks;
  logic [FRAME_W-1:0] shadow;
  logic               ov_flag, len_flag, cks_flag, hdr_flag;
  logic [3:0]         accepted;
  logic [7:0]         tx_shreg;
  status_byte_t       status;

  logic [7:0] byte_next;
  logic       byte_end;
  logic       shift_en, hdr_ok, push_payload, commit;
  logic       set_hdr, set_len, set_cks;
  logic       overrun_set, load, err_inc;

  assign byte_next   = {shreg[6:0], sdi_lvl};
  assign byte_end    = (bit_cnt == 3'd7);
  assign overrun_set = commit & frame_valid & ~frame_ready;
  assign load        = commit & ~overrun_set;
  assign err_inc     = set_hdr | set_len | set_cks;
  assign status      = {ov_flag, len_flag, cks_flag, hdr_flag, accepted};

  // FSM state register
  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  // Next state and per-clock strobes; a ce fall overrides everything else
  always_comb begin
    next_state   = state;
    shift_en     = 1'b0;
    hdr_ok       = 1'b0;
    push_payload = 1'b0;
    commit       = 1'b0;
    set_hdr      = 1'b0;
    set_len      = 1'b0;
    set_cks      = 1'b0;
    if (ce_fall) begin
      next_state = IDLE;
      if (state == DONE && bit_cnt == 3'd0) commit = 1'b1;
      else if (state != IDLE && state != DRAIN) set_len = 1'b1;
    end else begin
      case (state)
        IDLE: if (ce_rise) next_state = HEADER;
        HEADER: if (sck_rise) begin
          shift_en = 1'b1;
          if (byte_end) begin
            if (byte_next == HEADER_BYTE) begin
              hdr_ok     = 1'b1;
              next_state = PAYLOAD;
            end else begin
              set_hdr    = 1'b1;
              next_state = DRAIN;
            end
          end
        end
        PAYLOAD: if (sck_rise) begin
          shift_en = 1'b1;
          if (byte_end) begin
            push_payload = 1'b1;
            if (byte_cnt == LAST_BYTE) next_state = CHECK;
          end
        end
        CHECK: if (sck_rise) begin
          shift_en = 1'b1;
          if (byte_end) begin
            if (byte_next == cks) begin
              next_state = DONE;
            end else begin
              set_cks    = 1'b1;
              next_state = DRAIN;
            end
          end
        end
        DONE: if (sck_rise) begin
          set_len    = 1'b1;
          next_state = DRAIN;
        end
        default: ;
      endcase
    end
  end

  // Bit/byte assembly, checksum and shadow payload buffer
  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      cks      <= '0;
      shadow   <= '0;
    end else begin
      if (ce_rise || ce_fall) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= byte_next;
        bit_cnt <= bit_cnt + 3'd1;
        if (push_payload) byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (hdr_ok) cks <= byte_next;
      else if (push_payload) cks <= cks ^ byte_next;
      if (push_payload) shadow <= (shadow >> 8) | (FRAME_W'(byte_next) << (FRAME_W - 8));
    end
  end

  // Consumer handshake and reject counter
  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      err_count   <= '0;
      accepted    <= '0;
    end else begin
      if (load) begin
        frame_data  <= shadow;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (commit) accepted <= accepted + 4'd1;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Status flags cleared by the ce-rise snapshot; same-clock events survive into the new epoch
  always_ff @(posedge HSOSC_clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_flag  <= 1'b0;
      len_flag <= 1'b0;
      cks_flag <= 1'b0;
      hdr_flag <= 1'b0;
      sdo      <= 1'b0;
      tx_shreg <= '0;
    end else begin
      ov_flag  <= (ce_rise ? 1'b0 : ov_flag) | overrun_set;
      len_flag <= (ce_rise ? 1'b0 : len_flag) | set_len;
      cks_flag <= (ce_rise ? 1'b0 : cks_flag) | set_cks;
      hdr_flag <= (ce_rise ? 1'b0 : hdr_flag) | set_hdr;
      if (ce_rise) begin
        sdo      <= status[7];
        tx_shreg <= {status[6:0], 1'b0};
      end else if (next_state == IDLE) begin
        sdo      <= 1'b0;
        tx_shreg <= '0;
      end else if (sck_fall) begin
        sdo      <= tx_shreg[7];
        tx_shreg <= {tx_shreg[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: directed and randomized packets against a packet-level model.
module tb_spi_frame_receiver;

  localparam int unsigned PB        = 4;
  localparam int unsigned SYNC      = 2;
  localparam int          FULL_BITS = 8 * (PB + 2);

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sck = 1'b0, sdi = 1'b0, ce = 1'b0, frame_ready = 1'b0;
  logic        sdo, frame_valid, busy;
  logic [31:0] frame_data;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  // Packet-level model of what the receiver should report
  logic        m_ov, m_len, m_cks, m_hdr;
  logic [3:0]  m_acc;
  int          m_err;
  logic        m_valid;
  logic [31:0] m_data;
  logic [7:0]  last_st;

  spi_frame_receiver #(.PAYLOAD_BYTES(PB), .HEADER_BYTE(8'hA5), .SYNC_STAGES(SYNC)) dut (
    .HSOSC_clk(clk), .reset_n(reset_n), .sck(sck), .sdi(sdi), .ce(ce), .sdo(sdo),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_ov, m_len, m_cks, m_hdr} = 4'b0;
    m_acc = '0; m_err = 0; m_valid = 1'b0; m_data = '0;
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_txn(input bq_t b, input int nbits, input bit rdy, output logic [7:0] exp_st);
    logic [7:0] x;
    exp_st = {m_ov, m_len, m_cks, m_hdr, m_acc};
    {m_ov, m_len, m_cks, m_hdr} = 4'b0;
    if (nbits < 8) begin
      m_len = 1'b1; bump_err();
    end else if (b[0] != 8'hA5) begin
      m_hdr = 1'b1; bump_err();
    end else if (nbits < FULL_BITS) begin
      m_len = 1'b1; bump_err();
    end else begin
      x = 8'h00;
      for (int j = 0; j <= int'(PB); j++) x = x ^ b[j];
      if (b[PB+1] != x) begin
        m_cks = 1'b1; bump_err();
      end else if (nbits > FULL_BITS) begin
        m_len = 1'b1; bump_err();
      end else begin
        m_acc = m_acc + 4'd1;
        if (m_valid && !rdy) m_ov = 1'b1;
        else begin
          m_valid = 1'b1;
          for (int j = 0; j < int'(PB); j++) m_data[j*8 +: 8] = b[j+1];
        end
      end
    end
  endtask

  task automatic mk_pkt(input logic [31:0] pl, input logic [7:0] hdr, input bit bad_cks, output bq_t q);
    logic [7:0] x;
    q = {};
    q.push_back(hdr);
    x = hdr;
    for (int j = 0; j < int'(PB); j++) begin
      q.push_back(pl[j*8 +: 8]);
      x = x ^ pl[j*8 +: 8];
    end
    q.push_back(bad_cks ? (x ^ 8'h01) : x);
    q.push_back(8'($urandom));
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One SPI transaction at clk/8; rdy pulses frame_ready exactly on the commit clock
  task automatic send_txn(input bq_t b, input int nbits, input bit rdy, output logic [7:0] st);
    st = 8'h00;
    @(negedge clk); ce = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      send_bit(b[i/8][7 - (i % 8)]);
      if (i < 8) st[7 - i] = sdo;
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    ce = 1'b0; sdi = 1'b0;
    if (rdy) begin
      repeat (SYNC + 1) @(negedge clk);
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic run_txn(input string name, input bq_t b, input int nbits, input bit rdy);
    logic [7:0] exp_st;
    model_txn(b, nbits, rdy, exp_st);
    send_txn(b, nbits, rdy, last_st);
    if (nbits >= 8) check({name, " status"}, 32'(last_st), 32'(exp_st));
    check({name, " err_count"}, 32'(err_count), 32'(m_err));
    check({name, " valid"}, 32'(frame_valid), 32'(m_valid));
    if (m_valid) check({name, " data"}, frame_data, m_data);
    check({name, " sdo idle"}, 32'(sdo), 32'd0);
    check({name, " busy idle"}, 32'(busy), 32'd0);
  endtask

  task automatic accept();
    @(negedge clk); frame_ready = 1'b1;
    @(negedge clk); frame_ready = 1'b0;
    m_valid = 1'b0;
    check("accept valid", 32'(frame_valid), 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, " sdo"}, 32'(sdo), 32'd0);
    check({name, " frame_data"}, frame_data, 32'd0);
    check({name, " frame_valid"}, 32'(frame_valid), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd0);
    check({name, " err_count"}, 32'(err_count), 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset_n = 1'b0; ce = 1'b0; sck = 1'b0; sdi = 1'b0; frame_ready = 1'b0;
    #1;
    check_zero(name);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid(input bq_t b, input int stop_bit);
    @(negedge clk); ce = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < stop_bit; i++) begin
      send_bit(b[i/8][7 - (i % 8)]);
      sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("midreset busy before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    ce = 1'b0; sck = 1'b0; sdi = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bq_t q;
    int  kind, nb;
    model_reset();
    last_st = 8'h00;
    repeat (3) @(negedge clk);
    do_reset("reset");

    // Known-good packet, then a one-clock accept
    mk_pkt(32'h44332211, 8'hA5, 1'b0, q);
    check("t1 checksum byte", 32'(q[5]), 32'h0000_00E1);
    run_txn("t1", q, FULL_BITS, 1'b0);
    check("t1 valid", 32'(frame_valid), 32'd1);
    check("t1 data", frame_data, 32'h44332211);
    check("t1 err", 32'(err_count), 32'd0);
    accept();

    // Bad checksum, then bad header, short packet and a recovery packet
    do_reset("reset t2");
    mk_pkt(32'h44332211, 8'hA5, 1'b1, q);
    run_txn("t2", q, FULL_BITS, 1'b0);
    check("t2 err", 32'(err_count), 32'd1);
    mk_pkt(32'h44332211, 8'h5A, 1'b0, q);
    run_txn("t3 hdr", q, FULL_BITS, 1'b0);
    check("t2 next status", 32'(last_st), 32'h20);
    mk_pkt(32'h44332211, 8'hA5, 1'b0, q);
    run_txn("t3 short", q, 13, 1'b0);
    check("t3 hdr_err bit", 32'(last_st[4]), 32'd1);
    run_txn("t3 recover", q, FULL_BITS, 1'b0);
    check("t3 len_err bit", 32'(last_st[6]), 32'd1);

    // Two commits without ready: first payload kept, overrun reported
    do_reset("reset t4");
    mk_pkt($urandom, 8'hA5, 1'b0, q);
    run_txn("t4 first", q, FULL_BITS, 1'b0);
    mk_pkt($urandom, 8'hA5, 1'b0, q);
    run_txn("t4 second", q, FULL_BITS, 1'b0);
    mk_pkt(32'h0, 8'h00, 1'b0, q);
    run_txn("t4 probe", q, 8, 1'b0);
    check("t4 status", 32'(last_st), 32'h82);

    // Reset mid-payload, then normal commit
    mk_pkt($urandom, 8'hA5, 1'b0, q);
    reset_mid(q, 20);
    mk_pkt($urandom, 8'hA5, 1'b0, q);
    run_txn("t5 after", q, FULL_BITS, 1'b0);
    check("t5 valid", 32'(frame_valid), 32'd1);

    // Accept and commit on the same clock
    mk_pkt(32'hCAFE_F00D, 8'hA5, 1'b0, q);
    run_txn("t6", q, FULL_BITS, 1'b1);
    check("t6 valid", 32'(frame_valid), 32'd1);
    check("t6 data", frame_data, 32'hCAFE_F00D);

    // Random mix of good and faulty packets
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 4));
      nb   = FULL_BITS;
      case (kind)
        1: mk_pkt($urandom, 8'hA5, 1'b1, q);
        2: begin
          mk_pkt($urandom, 8'hA5 ^ 8'($urandom_range(1, 255)), 1'b0, q);
          nb = int'($urandom_range(8, FULL_BITS));
        end
        3: begin
          mk_pkt($urandom, 8'hA5, 1'b0, q);
          nb = int'($urandom_range(1, FULL_BITS - 1));
        end
        4: begin
          mk_pkt($urandom, 8'hA5, 1'b0, q);
          nb = int'($urandom_range(FULL_BITS + 1, FULL_BITS + 8));
        end
        default: mk_pkt($urandom, 8'hA5, 1'b0, q);
      endcase
      run_txn("rand", q, nb, 1'b0);
      if ($urandom_range(0, 1) == 1) accept();
    end

    // Drive the reject counter into saturation with short bad-header packets
    mk_pkt(32'h0, 8'h5A, 1'b0, q);
    for (int n = 0; n < 260; n++) run_txn("sat", q, 8, 1'b0);
    check("sat err_count", 32'(err_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
